// File: rtl/logic_unit_pipe_if.sv
// Handshake bundle for logic_unit_pipe: operand side and result side.
// master drives operands and out_ready; slave is the logic unit.
interface logic_unit_pipe_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [2:0]       op;
    logic             acc;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             zero;
    logic             parity;
    logic             illegal;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, a, b, op, acc, out_ready,
        input  in_ready, out_valid, y, zero, parity, illegal, op_count
    );

    modport slave (
        input  in_valid, a, b, op, acc, out_ready,
        output in_ready, out_valid, y, zero, parity, illegal, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Registered WIDTH-bit bitwise logic stage with accumulate and op counter.
// Define LOGIC_UNIT_EXT_OPS_EN to implement opcodes 4-7 (XOR/NAND/NOR/XNOR).
module logic_unit_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input logic clk,
    input logic rst_n,
    logic_unit_pipe_if.slave bus
);
    logic [WIDTH-1:0] y_q;
    logic [WIDTH-1:0] acc_q;
    logic [WIDTH-1:0] a_eff;
    logic [WIDTH-1:0] res;
    logic [CNT_W-1:0] cnt_q;
    logic             valid_q;
    logic             zero_q;
    logic             parity_q;
    logic             ill_q;
    logic             ill;
    logic             accept;

    assign bus.in_ready  = !valid_q || bus.out_ready;
    assign accept        = bus.in_valid && bus.in_ready;
    assign a_eff         = bus.acc ? acc_q : bus.a;

    assign bus.out_valid = valid_q;
    assign bus.y         = y_q;
    assign bus.zero      = zero_q;
    assign bus.parity    = parity_q;
    assign bus.illegal   = ill_q;
    assign bus.op_count  = cnt_q;

    always_comb begin
        res = '0;
        ill = 1'b0;
        unique case (bus.op)
            3'd0: res = a_eff & bus.b;
            3'd1: res = a_eff | bus.b;
            3'd2: res = ~a_eff;
            3'd3: res = a_eff;
`ifdef LOGIC_UNIT_EXT_OPS_EN
            3'd4: res = a_eff ^ bus.b;
            3'd5: res = ~(a_eff & bus.b);
            3'd6: res = ~(a_eff | bus.b);
            3'd7: res = ~(a_eff ^ bus.b);
`else
            // Unsupported ops still complete, with a zero result flagged.
            3'd4, 3'd5, 3'd6, 3'd7: ill = 1'b1;
`endif
            default: res = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q  <= 1'b0;
            y_q      <= '0;
            zero_q   <= 1'b1;
            parity_q <= 1'b0;
            ill_q    <= 1'b0;
            acc_q    <= '0;
            cnt_q    <= '0;
        end else if (accept) begin
            valid_q  <= 1'b1;
            y_q      <= res;
            zero_q   <= ~|res;
            parity_q <= ^res;
            ill_q    <= ill;
            acc_q    <= res;
            if (cnt_q != '1)
                cnt_q <= cnt_q + CNT_W'(1);
        end else if (bus.out_ready) begin
            valid_q  <= 1'b0;
        end
    end
endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
- Parametrised, registered successor to the team's fixed 1-bit AND/OR/NOT gate block.
- WIDTH-bit bitwise logic unit with opcode-selected function and a one-stage valid/ready output register.
- Includes an accumulate mode that chains results, and a saturating transaction counter.
- Feeds lab datapath exercises (ALU/flag experiments) as a drop-in registered logic stage.

Parameters:
- WIDTH, 8, operand/result width in bits (1..32).
- CNT_W, 16, width of the transaction counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  3  function select.
- acc  in  1  1 = use last result in place of a.
- out_valid  out  1  y/flags valid.
- out_ready  in  1  downstream accepts.
- y  out  WIDTH  registered result.
- zero  out  1  y == 0.
- parity  out  1  XOR-reduce of y.
- illegal  out  1  opcode not supported in this build.
- op_count  out  CNT_W  accepted transactions, saturating.

Behaviour:
- Interface: one clock, clk; reset asynchronous, active-low, rst_n.
- Reset (async assert, sync release): out_valid=0, y=0, zero=1, parity=0, illegal=0, op_count=0, internal acc_reg=0.
- Handshake:
  - in_ready = !out_valid | out_ready (combinational).
  - Accept when in_valid & in_ready.
  - Output handshake completes when out_valid & out_ready.
- Latency: result appears 1 cycle after accept; throughput 1/cycle under out_ready=1.
- Stall: out_valid=1 & out_ready=0 holds y, zero, parity, illegal stable; in_ready=0; no accept.
- Simultaneous drain and accept in the same cycle: out_valid stays 1 and registers load the new result (no bubble).
- Drain with no accept: out_valid goes 0 next cycle; y retains its last value.
- Operand select: A_eff = acc ? acc_reg : a.
- Opcodes: 0 AND, 1 OR, 2 NOT A_eff (b ignored), 3 PASS A_eff, 4 XOR, 5 NAND, 6 NOR, 7 XNOR. All bitwise, WIDTH bits, no carries.
- acc_reg loads the new y on every accept (acc=0 or 1).
- zero and parity are computed from the value being loaded and registered alongside y.
- op_count increments on every accept and saturates at 2^CNT_W-1 (no wrap).
- Reset mid-stall: the pending output is discarded; out_valid=0 immediately (async).

Optional Feature:
- Macro: LOGIC_UNIT_EXT_OPS_EN.
- Defined: opcodes 4-7 implemented as above; illegal is always 0.
- Undefined: opcodes 4-7 are still accepted and counted; y=0 (zero=1, parity=0); illegal=1 registered with that result; acc_reg loads 0.
- Opcodes 0-3 behave identically in both builds.

Test Plan:
- Reset: assert rst_n=0 mid-run -> out_valid=0, y=0, zero=1, op_count=0 without a clock edge.
- Basic ops, WIDTH=8, out_ready=1: a=0xF0, b=0x3C.
  - op0 -> y=0x30, parity=0.
  - op1 -> y=0xFC.
  - op2 -> y=0x0F.
  - Each result appears 1 cycle after accept.
- Accumulate: accept a=0xAA op3; then acc=1, b=0x0F, op1 -> y=0xAF; then acc=1, op2 -> y=0x50.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, y held. Release -> drain and accept in the same cycle, no lost or duplicated result, op_count +1 per accept.
- Counter saturation, CNT_W=4: accept 20 transactions -> op_count stops at 15.
- Ext ops, a=0xF0, b=0x3C, op4:
  - With macro: y=0xCC, illegal=0.
  - Without macro: y=0x00, zero=1, illegal=1, op_count increments.
